// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC measurement sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_TOGGLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } meas_state_t;

  // Hamming-weight width: must represent 0..N inclusive.
  function automatic int hw_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Cycles from a pattern toggle until its popcount is valid at hw_in:
  // sync stages + popcount latency + one cycle for the toggle to land.
  function automatic int settle_cycles(input int n_sync, input int pc_lat);
    return n_sync + pc_lat + 1;
  endfunction

endpackage

// File: rtl/tdc_stat_acc.sv
// Sample statistics accumulator: running sum, min, max and sample count.
// Latency: one cycle from acc to updated registers.
// Backpressure: none; acc is a single-cycle strobe, clr restarts all stats.
// Ports: clk, rst (sync, active-high), clr, acc, v (sample);
//        sum, min_v, max_v, cnt (current statistics).
module tdc_stat_acc
  import tdc_pkg::*;
#(
  parameter int HW_W   = 7,
  parameter int SAMP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     acc,
  input  logic [HW_W-1:0]          v,
  output logic [HW_W+SAMP_W-1:0]   sum,
  output logic [HW_W-1:0]          min_v,
  output logic [HW_W-1:0]          max_v,
  output logic [SAMP_W-1:0]        cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum   <= '0;
      min_v <= '1;  // all-ones so the first sample always wins
      max_v <= '0;
      cnt   <= '0;
    end else if (acc) begin
      sum <= sum + {{SAMP_W{1'b0}}, v};
      if (v < min_v) min_v <= v;
      if (v > max_v) max_v <= v;
      cnt <= cnt + SAMP_W'(1);
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: arm, toggle/settle/sample n times, report sum/min/max.
// Latency: result valid 1+SETTLE+(SETTLE+2)*n cycles after the start cycle.
// Backpressure: result held in DONE until res_ready; start ignored unless IDLE.
// Ports: clk, rst (sync, active-high); start, n_samples (request); busy;
//        tdc_en, pg_tog (to tdc_top), hw_in (from tdc_top);
//        res_valid/res_ready handshake with res_sum, res_min, res_max, res_cnt.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int N        = 64,
  parameter int N_SYNC   = 2,
  parameter int PC_LAT   = 1,
  parameter int SAMP_W   = 8,
  parameter int NORM_POL = 1,
  localparam int HW_W    = hw_width(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SAMP_W-1:0]      n_samples,
  output logic                   busy,
  output logic                   tdc_en,
  output logic                   pg_tog,
  input  logic [HW_W-1:0]        hw_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [HW_W+SAMP_W-1:0] res_sum,
  output logic [HW_W-1:0]        res_min,
  output logic [HW_W-1:0]        res_max,
  output logic [SAMP_W-1:0]      res_cnt
);

  localparam int SETTLE = settle_cycles(N_SYNC, PC_LAT);
  localparam int SC_W   = $clog2(SETTLE + 1);

  meas_state_t       state_q, state_d;
  logic [SC_W-1:0]   settle_cnt_q;
  logic [SAMP_W-1:0] n_lat_q;
  logic              pg_lvl_q;
  logic              settle_done;
  logic              last_samp;
  logic              acc_clr;
  logic              acc_en;
  logic [HW_W-1:0]   samp_v;

  assign settle_done = (settle_cnt_q == SC_W'(SETTLE - 1));
  // res_cnt counts samples already taken; this one is the last if it reaches n.
  assign last_samp   = ((res_cnt + SAMP_W'(1)) == n_lat_q);

  // pg_lvl_q is the pattern-generator output level after the last toggle.
  // Level 0 means the most recent edge was falling, whose popcount counts
  // zeros rather than ones, so it is mirrored back as N-hw.
  always_comb begin
    samp_v = hw_in;
    if (NORM_POL != 0 && !pg_lvl_q) samp_v = HW_W'(N) - hw_in;
  end

  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (n_samples != '0)) begin
          state_d = ST_ARM;
          acc_clr = 1'b1;
        end
      end
      ST_ARM:    if (settle_done) state_d = ST_TOGGLE;
      ST_TOGGLE: state_d = ST_WAIT;
      ST_WAIT:   if (settle_done) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        acc_en  = 1'b1;
        state_d = last_samp ? ST_DONE : ST_TOGGLE;
      end
      ST_DONE:   if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      n_lat_q      <= '0;
      pg_lvl_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Free-runs only while arming or waiting; zero on entry to either.
      if ((state_q == ST_ARM || state_q == ST_WAIT) && !settle_done)
        settle_cnt_q <= settle_cnt_q + SC_W'(1);
      else
        settle_cnt_q <= '0;
      if (acc_clr) n_lat_q <= n_samples;
      // Level persists across measurements, mirroring the real pg output.
      if (state_q == ST_TOGGLE) pg_lvl_q <= ~pg_lvl_q;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign tdc_en    = (state_q == ST_ARM) || (state_q == ST_TOGGLE) ||
                     (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
  assign pg_tog    = (state_q == ST_TOGGLE);
  assign res_valid = (state_q == ST_DONE);

  tdc_stat_acc #(
    .HW_W   (HW_W),
    .SAMP_W (SAMP_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .acc   (acc_en),
    .v     (samp_v),
    .sum   (res_sum),
    .min_v (res_min),
    .max_v (res_max),
    .cnt   (res_cnt)
  );

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: two instances (raw and normalised) share stimulus.
// Latency: checks first-valid cycle against 1+SETTLE+(SETTLE+2)*n.
// Backpressure: exercises res_ready held low in DONE and ignored start pulses.
module tb_tdc_meas_ctrl;

  localparam int SETTLE = 4;  // N_SYNC=2, PC_LAT=1

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  n_samples;
  logic [6:0]  hw_in;
  logic        res_ready;

  logic        busy0, tdc_en0, pg_tog0, valid0;
  logic [14:0] sum0;
  logic [6:0]  min0, max0;
  logic [7:0]  cnt0;
  logic        busy1, tdc_en1, pg_tog1, valid1;
  logic [14:0] sum1;
  logic [6:0]  min1, max1;
  logic [7:0]  cnt1;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int t0     = 0;
  int tog_cnt = 0;
  int cd     = 0;
  int idx    = 0;
  int hw_vec [256];

  tdc_meas_ctrl #(.N(64), .N_SYNC(2), .PC_LAT(1), .SAMP_W(8), .NORM_POL(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .busy(busy0),
    .tdc_en(tdc_en0), .pg_tog(pg_tog0), .hw_in(hw_in), .res_valid(valid0),
    .res_ready(res_ready), .res_sum(sum0), .res_min(min0), .res_max(max0), .res_cnt(cnt0)
  );

  tdc_meas_ctrl #(.N(64), .N_SYNC(2), .PC_LAT(1), .SAMP_W(8), .NORM_POL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .busy(busy1),
    .tdc_en(tdc_en1), .pg_tog(pg_tog1), .hw_in(hw_in), .res_valid(valid1),
    .res_ready(res_ready), .res_sum(sum1), .res_min(min1), .res_max(max1), .res_cnt(cnt1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // hw_in source: junk everywhere except the single SAMPLE cycle that follows
  // each toggle by SETTLE+1 cycles, where the next scripted value is presented.
  initial begin
    hw_in = '0;
    forever begin
      @(negedge clk);
      if (rst) cd = 0;
      if (pg_tog0) begin
        cd = SETTLE + 2;
        tog_cnt = tog_cnt + 1;
      end else if (cd > 0) begin
        cd = cd - 1;
      end
      if (cd == 1 && idx < 256) begin
        hw_in = 7'(hw_vec[idx]);
        idx = idx + 1;
      end else begin
        hw_in = 7'($urandom_range(0, 64));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n);
    idx = 0;
    cd = 0;
    tog_cnt = 0;
    n_samples = 8'(n);
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
  endtask

  // Returns the cycle index (start cycle = 0) at which valid is first seen.
  task automatic wait_valid(output int at);
    int guard;
    guard = 0;
    while (!valid0 && guard < 4000) begin
      tick();
      guard = guard + 1;
    end
    at = cyc - t0 + 1;
    check_val("valid_timeout", int'(valid0), 1);
  endtask

  task automatic wait_pg();
    int guard;
    guard = 0;
    while (!pg_tog0 && guard < 100) begin
      @(negedge clk);
      guard = guard + 1;
    end
    check_val("pg_timeout", int'(pg_tog0), 1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int at;
    int tog_before;
    rst = 1'b1;
    start = 1'b0;
    n_samples = '0;
    res_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_busy", int'(busy0), 0);
    check_val("rst_tdc_en", int'(tdc_en0), 0);
    check_val("rst_pg_tog", int'(pg_tog0), 0);
    check_val("rst_valid", int'(valid0), 0);
    check_val("rst_sum", int'(sum0), 0);
    check_val("rst_min", int'(min0), 127);
    check_val("rst_max", int'(max0), 0);
    check_val("rst_cnt", int'(cnt0), 0);
    rst = 1'b0;
    tick();

    // start with n_samples == 0 is ignored
    n_samples = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("n0_busy", int'(busy0), 0);
    check_val("n0_tdc_en", int'(tdc_en0), 0);
    tick();
    check_val("n0_busy_later", int'(busy0), 0);

    // Reset in the middle of WAIT aborts cleanly
    hw_vec[0] = 33;
    launch(4);
    wait_pg();
    tick();
    tick();
    check_val("midwait_tdc_en", int'(tdc_en0), 1);
    rst = 1'b1;
    tick();
    check_val("abort_busy", int'(busy0), 0);
    check_val("abort_tdc_en", int'(tdc_en0), 0);
    check_val("abort_valid", int'(valid0), 0);
    check_val("abort_min", int'(min0), 127);
    check_val("abort_cnt", int'(cnt0), 0);
    rst = 1'b0;
    tick();

    // n=4, hw 10,20,5,30 (rising, falling, rising, falling)
    hw_vec[0] = 10; hw_vec[1] = 20; hw_vec[2] = 5; hw_vec[3] = 30;
    launch(4);
    wait_valid(at);
    check_val("n4_valid_cycle", at, 29);
    check_val("n4_sum_raw", int'(sum0), 65);
    check_val("n4_min_raw", int'(min0), 5);
    check_val("n4_max_raw", int'(max0), 30);
    check_val("n4_cnt_raw", int'(cnt0), 4);
    check_val("n4_sum_norm", int'(sum1), 93);
    check_val("n4_min_norm", int'(min1), 5);
    check_val("n4_max_norm", int'(max1), 44);
    check_val("n4_pg_count", tog_cnt, 4);

    // Hold res_ready low in DONE; start pulses must not disturb anything
    tog_before = tog_cnt;
    for (int i = 0; i < 10; i++) begin
      start = (i % 3 == 0);
      n_samples = 8'd3;
      tick();
      check_val("stall_valid", int'(valid0), 1);
    end
    start = 1'b0;
    check_val("stall_sum", int'(sum0), 65);
    check_val("stall_cnt", int'(cnt0), 4);
    check_val("stall_no_pg", tog_cnt, tog_before);
    handshake();
    check_val("ack_valid", int'(valid0), 0);
    check_val("ack_busy", int'(busy0), 0);
    check_val("ack_sum_hold", int'(sum0), 65);
    check_val("ack_max_hold", int'(max0), 30);
    tick();
    tick();
    check_val("ack_no_restart", int'(busy0), 0);

    // n=2, hw 10 then 50; stray start during WAIT is ignored
    hw_vec[0] = 10; hw_vec[1] = 50;
    launch(2);
    wait_pg();
    tick();
    start = 1'b1;
    n_samples = 8'd5;
    tick();
    start = 1'b0;
    check_val("wait_start_tdc_en", int'(tdc_en0), 1);
    wait_valid(at);
    check_val("n2_valid_cycle", at, 17);
    check_val("n2_sum_norm", int'(sum1), 24);
    check_val("n2_min_norm", int'(min1), 10);
    check_val("n2_max_norm", int'(max1), 14);
    check_val("n2_cnt", int'(cnt0), 2);
    check_val("n2_sum_raw", int'(sum0), 60);
    check_val("n2_max_raw", int'(max0), 50);
    handshake();

    // n=255 full-scale samples: no wrap in the sum
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) hw_vec[i] = 64;
    launch(255);
    wait_valid(at);
    check_val("n255_valid_cycle", at, 1535);
    check_val("n255_sum_raw", int'(sum0), 16320);
    check_val("n255_min_raw", int'(min0), 64);
    check_val("n255_max_raw", int'(max0), 64);
    check_val("n255_cnt", int'(cnt0), 255);
    check_val("n255_pg_count", tog_cnt, 255);
    check_val("n255_sum_norm", int'(sum1), 8192);
    check_val("n255_min_norm", int'(min1), 0);
    check_val("n255_max_norm", int'(max1), 64);
    handshake();
    check_val("n255_ack_valid", int'(valid0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
